// File: rtl/multi_channel_debounce.sv
// multi_channel_debounce
// Per-channel level filter: level_out follows the sampled input only after
// STABLE_CYCLES consecutive disagreeing samples. In sym_mode = 0 a falling
// input drops level_out immediately (legacy behaviour). An optional
// synchroniser chain sits ahead of the filter. rise_pulse / fall_pulse mark
// the cycle after a level_out change. enable = 0 freezes all state and
// forces the pulses low. There is no handshake: inputs are sampled every
// enabled clock, and outputs are valid every cycle.
module multi_channel_debounce #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 0,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                sym_mode,
  input  logic [CHANNELS-1:0] in_raw,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Sampled input seen by the filter (synchroniser output or raw input).
  logic [CHANNELS-1:0] s;

  // Per-channel count of consecutive samples disagreeing with level_out.
  logic [CNT_W-1:0] cnt [CHANNELS];

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = in_raw;
    end else begin : g_sync
      logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

      // Synchroniser chain; shifts only on enabled clocks so a paused
      // filter does not lose samples already in flight.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= {CHANNELS{RESET_LEVEL}};
          end
        end else if (enable) begin
          sync_q[0] <= in_raw;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Filter: per-channel agreement counter, level register and edge pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_out  <= {CHANNELS{RESET_LEVEL}};
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt[c] <= '0;
      end
    end else if (enable) begin
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (s[c] == level_out[c]) begin
          // Any agreeing sample restarts the count: glitch rejection.
          cnt[c] <= '0;
        end else if (!sym_mode && !s[c]) begin
          // Legacy immediate fall; also completes a fall count in progress
          // when sym_mode has just been cleared.
          level_out[c]  <= 1'b0;
          cnt[c]        <= '0;
          fall_pulse[c] <= 1'b1;
        end else if (cnt[c] == CNT_LAST) begin
          level_out[c]  <= s[c];
          cnt[c]        <= '0;
          rise_pulse[c] <= s[c];
          fall_pulse[c] <= ~s[c];
        end else begin
          cnt[c] <= cnt[c] + 1'b1;
        end
      end
    end else begin
      // Paused: counters, levels and synchroniser hold; pulses are quiet.
      rise_pulse <= '0;
      fall_pulse <= '0;
    end
  end

endmodule

// File: doc/multi_channel_debounce.md
Name: multi_channel_debounce

Overview:
- Parametrised, multi-channel successor to the fixed 4-stage confirm/delay block.
- Each channel drives its filtered output to a new level only after the raw input has held that level for STABLE_CYCLES consecutive sampled clocks.
- Adds an optional input synchroniser, a selectable falling-edge mode (immediate or confirmed), an enable, and one-cycle edge pulses.
- Sits between raw button/switch/sensor inputs and the control FSMs.

Parameters:
- CHANNELS, 4: number of independent channels.
- STABLE_CYCLES, 4: consecutive agreeing samples required before a level change (legal range 1..255).
- SYNC_STAGES, 0: synchroniser flops ahead of the filter (legal range 0..3; 0 means in_raw is sampled directly).
- RESET_LEVEL, 0: value loaded into synchroniser flops and level_out at reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  filter advance enable; when low, all state holds.
- sym_mode  input  1  0 = confirm rising only, fall is immediate (legacy behaviour); 1 = confirm both edges.
- in_raw  input  CHANNELS  raw channel inputs.
- level_out  output  CHANNELS  filtered levels, registered.
- rise_pulse  output  CHANNELS  one-cycle pulse when level_out goes 0->1.
- fall_pulse  output  CHANNELS  one-cycle pulse when level_out goes 1->0.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - level_out = {CHANNELS{RESET_LEVEL}}.
  - rise_pulse and fall_pulse = 0.
  - Per-channel counters = 0.
  - Synchroniser flops = RESET_LEVEL.
  - reset has priority over enable.
  - Reset asserted mid-count discards any partial count.
- Sampled input s[i]:
  - SYNC_STAGES = 0: s[i] = in_raw[i].
  - Otherwise: s[i] is the output of a SYNC_STAGES-deep flop chain.
  - The chain shifts only when enable = 1.
- Counter: cnt[i] has width clog2(STABLE_CYCLES+1). Per channel, on each clk edge with enable = 1 and reset = 0:
  - s == level_out: cnt <= 0.
  - s != level_out, sym_mode = 0, s = 0: level_out <= 0 this edge (immediate fall), cnt <= 0, fall_pulse <= 1.
  - s != level_out, otherwise: if cnt == STABLE_CYCLES-1 then level_out <= s, cnt <= 0, and the matching pulse <= 1; else cnt <= cnt+1.
- Counting rules:
  - Any single sample equal to level_out during a count restarts it from 0; glitches are rejected.
  - The counter never exceeds STABLE_CYCLES-1; no wrap is possible.
- Pulses:
  - High for exactly the one cycle after the level_out change.
  - 0 on every other cycle, including all cycles with enable = 0.
  - rise_pulse and fall_pulse are never both high on one channel.
- Latency, with an input change settled before edge k:
  - Confirmed change: level_out updates at edge k + SYNC_STAGES + STABLE_CYCLES - 1.
  - Immediate fall (sym_mode = 0): level_out updates at edge k + SYNC_STAGES.
  - STABLE_CYCLES = 1 degenerates to a registered copy of s.
- enable = 0: cnt, level_out and synchroniser hold; pulses forced 0. Counting resumes from the held cnt.
- sym_mode change mid-count: takes effect on the next edge; no reset of cnt. If switching to 0 while a fall count is in progress, the fall completes on that edge.
- Channels are fully independent; simultaneous events on different channels are handled in parallel.
- With CHANNELS = 1, STABLE_CYCLES = 4, SYNC_STAGES = 0, sym_mode = 0 and enable = 1, behaviour is cycle-equivalent to the legacy 4-stage confirm block.

Test Plan:
- Legacy equivalence (CH = 1, N = 4, SYNC = 0, sym_mode = 0): in_raw 0->1 before edge 0, held high -> level_out = 1 after edge 3 and rise_pulse = 1 for one cycle after edge 3. in_raw -> 0 before edge 10 -> level_out = 0 and fall_pulse = 1 after edge 10.
- Glitch rejection (N = 4): in_raw high for 3 cycles, low for 1, then high for 4 -> level_out stays 0 through the first burst and rises only after the 4th sample of the second burst; exactly one rise_pulse.
- Symmetric mode (sym_mode = 1, N = 4, level_out = 1): in_raw low for 2 cycles then high -> level_out stays 1, no fall_pulse. Then in_raw low for 4 cycles -> level_out = 0 after the 4th sample, with one fall_pulse.
- Synchroniser and enable (SYNC = 2, N = 3): in_raw rises before edge 0 -> level_out = 1 after edge 4. Repeat with enable = 0 for 2 cycles mid-count -> rise delayed by exactly 2 edges, and pulses stay 0 while enable = 0.
- Reset mid-count (RESET_LEVEL = 0, N = 4): assert reset at edge 2 of a rising count -> after that edge level_out = 0, pulses 0, cnt = 0. Deassert with in_raw still high -> rise occurs 4 samples later.
- Multi-channel independence (CH = 4, N = 2): ch0 rises, ch1 falls (sym_mode = 1), ch2 glitches 1 cycle, ch3 static, all on the same edges -> ch0 rise_pulse and ch1 fall_pulse on the same cycle; ch2 and ch3 unchanged with no pulses.
